// File: rtl/posit_encoder_if.sv
// Handshake bundle between Posit_Adder's decoded result and the posit encoder.
// The master side produces decoded beats and consumes encoded posits.
interface posit_encoder_if #(
   parameter int N  = 8,
   parameter int ES = 3
);
   localparam int RS  = $clog2(N);
   localparam int LEW = ES + RS + 1;

   logic           in_valid;
   logic           in_ready;
   logic           in_sign;
   logic           in_zero;
   logic           in_nar;
   logic [LEW-1:0] in_le;
   logic [N-1:0]   in_mant;
   logic           in_sticky;
   logic           out_valid;
   logic           out_ready;
   logic [N-1:0]   out_posit;

   modport master (
      output in_valid, in_sign, in_zero, in_nar, in_le, in_mant, in_sticky, out_ready,
      input  in_ready, out_valid, out_posit
   );

   modport slave (
      input  in_valid, in_sign, in_zero, in_nar, in_le, in_mant, in_sticky, out_ready,
      output in_ready, out_valid, out_posit
   );
endinterface

// File: rtl/posit_encoder.sv
// Three-stage posit packer: splits the scale, builds the regime/exponent/fraction
// body with guard and sticky, then rounds to nearest even with saturation.
module posit_encoder #(
   parameter int N  = 8,
   parameter int ES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   posit_encoder_if.slave   bus
);
   localparam int RS  = $clog2(N);
   localparam int LEW = ES + RS + 1;
   localparam int W   = 3 * N;
   localparam int PAD = W - 2 - ES - (N - 1);
   localparam logic signed [RS:0] K_MAX = (RS + 1)'(N - 2);
   localparam logic signed [RS:0] K_MIN = (RS + 1)'(-(N - 1));

   logic adv;

   logic                 s1_valid_q, s1_valid_d;
   logic                 s1_sign_q, s1_sign_d;
   logic                 s1_zero_q, s1_zero_d;
   logic                 s1_nar_q, s1_nar_d;
   logic                 s1_sticky_q, s1_sticky_d;
   logic signed [RS:0]   s1_k_q, s1_k_d;
   logic [ES-1:0]        s1_e_q, s1_e_d;
   logic [N-2:0]         s1_frac_q, s1_frac_d;

   logic                 s2_valid_q, s2_valid_d;
   logic                 s2_sign_q, s2_sign_d;
   logic                 s2_zero_q, s2_zero_d;
   logic                 s2_nar_q, s2_nar_d;
   logic [N-2:0]         s2_body_q, s2_body_d;
   logic                 s2_guard_q, s2_guard_d;
   logic                 s2_sticky_q, s2_sticky_d;

   logic                 out_valid_q, out_valid_d;
   logic [N-1:0]         out_posit_q, out_posit_d;

   logic                 k_pos;
   logic [RS-1:0]        shift_amt;
   logic [W-1:0]         base;
   logic [W-1:0]         shifted;
   logic                 round_up;
   logic [N-1:0]         mag;
   logic [N-1:0]         result;

   assign adv           = bus.out_ready | ~out_valid_q;
   assign bus.in_ready  = adv;
   assign bus.out_valid = out_valid_q;
   assign bus.out_posit = out_posit_q;

   // The upper bits of the two's-complement scale are exactly floor(le / 2^ES).
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_sign_d   = s1_sign_q;
      s1_zero_d   = s1_zero_q;
      s1_nar_d    = s1_nar_q;
      s1_sticky_d = s1_sticky_q;
      s1_k_d      = s1_k_q;
      s1_e_d      = s1_e_q;
      s1_frac_d   = s1_frac_q;
      if (adv) begin
         s1_valid_d  = bus.in_valid;
         s1_sign_d   = bus.in_sign;
         s1_zero_d   = bus.in_zero;
         s1_nar_d    = bus.in_nar;
         s1_sticky_d = bus.in_sticky;
         s1_k_d      = $signed(bus.in_le[LEW-1:ES]);
         s1_e_d      = bus.in_le[ES-1:0];
         s1_frac_d   = bus.in_mant[N-2:0];
      end
   end

   // Seed "10" or "01" and arithmetic-shift so the sign bit replicates the regime run.
   always_comb begin
      k_pos     = ~s1_k_q[RS];
      shift_amt = k_pos ? s1_k_q[RS-1:0] : ~s1_k_q[RS-1:0];
      base      = {k_pos, ~k_pos, s1_e_q, s1_frac_q, {PAD{1'b0}}};
      shifted   = $signed(base) >>> shift_amt;

      s2_valid_d  = s2_valid_q;
      s2_sign_d   = s2_sign_q;
      s2_zero_d   = s2_zero_q;
      s2_nar_d    = s2_nar_q;
      s2_body_d   = s2_body_q;
      s2_guard_d  = s2_guard_q;
      s2_sticky_d = s2_sticky_q;
      if (adv) begin
         s2_valid_d = s1_valid_q;
         s2_sign_d  = s1_sign_q;
         s2_zero_d  = s1_zero_q;
         s2_nar_d   = s1_nar_q;
         if (s1_k_q >= K_MAX) begin
            s2_body_d   = {(N-1){1'b1}};
            s2_guard_d  = 1'b0;
            s2_sticky_d = 1'b0;
         end else if (s1_k_q <= K_MIN) begin
            s2_body_d   = {{(N-2){1'b0}}, 1'b1};
            s2_guard_d  = 1'b0;
            s2_sticky_d = 1'b0;
         end else begin
            s2_body_d   = shifted[W-1 -: N-1];
            s2_guard_d  = shifted[W-N];
            s2_sticky_d = (|shifted[W-N-1:0]) | s1_sticky_q;
         end
      end
   end

   // Round to nearest even; a carry out of the body clamps back to maxpos.
   always_comb begin
      round_up = s2_guard_q & (s2_sticky_q | s2_body_q[0]);
      mag      = {1'b0, s2_body_q} + {{(N-1){1'b0}}, round_up};
      if (mag[N-1]) begin
         mag = {1'b0, {(N-1){1'b1}}};
      end
      result = s2_sign_q ? (~mag + {{(N-1){1'b0}}, 1'b1}) : mag;
      if (s2_nar_q) begin
         result = {1'b1, {(N-1){1'b0}}};
      end else if (s2_zero_q) begin
         result = '0;
      end

      out_valid_d = out_valid_q;
      out_posit_d = out_posit_q;
      if (adv) begin
         out_valid_d = s2_valid_q;
         out_posit_d = result;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_zero_q   <= 1'b0;
         s1_nar_q    <= 1'b0;
         s1_sticky_q <= 1'b0;
         s1_k_q      <= '0;
         s1_e_q      <= '0;
         s1_frac_q   <= '0;
         s2_valid_q  <= 1'b0;
         s2_sign_q   <= 1'b0;
         s2_zero_q   <= 1'b0;
         s2_nar_q    <= 1'b0;
         s2_body_q   <= '0;
         s2_guard_q  <= 1'b0;
         s2_sticky_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_posit_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sign_q   <= s1_sign_d;
         s1_zero_q   <= s1_zero_d;
         s1_nar_q    <= s1_nar_d;
         s1_sticky_q <= s1_sticky_d;
         s1_k_q      <= s1_k_d;
         s1_e_q      <= s1_e_d;
         s1_frac_q   <= s1_frac_d;
         s2_valid_q  <= s2_valid_d;
         s2_sign_q   <= s2_sign_d;
         s2_zero_q   <= s2_zero_d;
         s2_nar_q    <= s2_nar_d;
         s2_body_q   <= s2_body_d;
         s2_guard_q  <= s2_guard_d;
         s2_sticky_q <= s2_sticky_d;
         out_valid_q <= out_valid_d;
         out_posit_q <= out_posit_d;
      end
   end
endmodule

// File: tb/tb_posit_encoder.sv
// Self-checking bench for posit_encoder: directed vector table, randomized traffic
// against a bit-string reference model, plus backpressure and async-reset sequences.
module tb_posit_encoder;
   localparam int N  = 8;
   localparam int ES = 3;

   typedef struct {
      string      name;
      logic [6:0] le;
      logic [7:0] mant;
      logic       sign;
      logic       sticky;
      logic       zero;
      logic       nar;
      logic [7:0] expPosit;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   assertCount = 0;
   int   failCount   = 0;
   bit   scoreOn     = 1'b0;
   logic [7:0] expQ[$];
   vec_t vecs[16];

   always #5 clk = ~clk;

   posit_encoder_if #(.N(N), .ES(ES)) bus ();

   posit_encoder #(.N(N), .ES(ES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Count every comparison and report a single FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Reference: write the posit bit string out explicitly, then round the first N-1 bits.
   function automatic logic [7:0] posModel(input logic sign, input logic zero, input logic nar,
                                           input logic [6:0] leBits, input logic [7:0] mant,
                                           input logic sticky);
      int le, k, e, mag;
      bit bits[$];
      bit guard, st;
      if (nar) return 8'h80;
      if (zero) return 8'h00;
      le = int'($signed(leBits));
      if (le >= 0) k = le / 8;
      else k = -((-le + 7) / 8);
      e = le - 8 * k;
      if (k >= N - 2) mag = 2 ** (N - 1) - 1;
      else if (k <= -(N - 1)) mag = 1;
      else begin
         if (k >= 0) begin
            repeat (k + 1) bits.push_back(1'b1);
            bits.push_back(1'b0);
         end else begin
            repeat (-k) bits.push_back(1'b0);
            bits.push_back(1'b1);
         end
         for (int i = ES - 1; i >= 0; i--) bits.push_back(e[i]);
         for (int i = N - 2; i >= 0; i--) bits.push_back(mant[i]);
         mag = 0;
         for (int i = 0; i < N - 1; i++) mag = mag * 2 + int'(bits[i]);
         guard = bits[N-1];
         st = sticky;
         for (int i = N; i < bits.size(); i++) st = st | bits[i];
         if (guard && (st || (mag % 2 == 1))) mag++;
         if (mag > 2 ** (N - 1) - 1) mag = 2 ** (N - 1) - 1;
      end
      if (sign) mag = 256 - mag;
      return mag[7:0];
   endfunction

   // Scoreboard: predict on input acceptance, compare on output acceptance.
   always @(negedge clk) begin
      if (!rst_n) begin
         expQ.delete();
      end else if (scoreOn) begin
         if (bus.out_valid && bus.out_ready) begin
            checkOutput("scoreboard beat expected", (expQ.size() > 0), 1);
            if (expQ.size() > 0) checkOutput("scoreboard posit", bus.out_posit, expQ.pop_front());
         end
         if (bus.in_valid && bus.in_ready)
            expQ.push_back(posModel(bus.in_sign, bus.in_zero, bus.in_nar, bus.in_le, bus.in_mant, bus.in_sticky));
      end
   end

   // Present one beat and check both its latency and its encoding.
   task automatic applyStimulus(input vec_t v);
      int lat;
      @(posedge clk); #1;
      bus.in_valid  = 1'b1;
      bus.in_le     = v.le;
      bus.in_mant   = v.mant;
      bus.in_sign   = v.sign;
      bus.in_sticky = v.sticky;
      bus.in_zero   = v.zero;
      bus.in_nar    = v.nar;
      checkOutput({v.name, " in_ready"}, bus.in_ready, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput({v.name, " latency"}, lat, 3);
      checkOutput(v.name, bus.out_posit, v.expPosit);
   endtask

   task automatic driveBeat(input logic [6:0] le, input logic [7:0] mant, input logic sign);
      bus.in_valid  = 1'b1;
      bus.in_le     = le;
      bus.in_mant   = mant;
      bus.in_sign   = sign;
      bus.in_sticky = 1'b0;
      bus.in_zero   = 1'b0;
      bus.in_nar    = 1'b0;
   endtask

   initial begin
      automatic int accepted = 0;
      automatic int got = 0;
      automatic int waitCnt = 0;
      automatic logic [7:0] held;
      logic [7:0] bpExp[$];

      vecs[0]  = '{"one",            7'd0,    8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40};
      vecs[1]  = '{"k-1 e2 pos",     7'h7A,   8'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h2A};
      vecs[2]  = '{"k-1 e2 neg",     7'h7A,   8'hC0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hD6};
      vecs[3]  = '{"tie lsb1",       7'd0,    8'hB0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h42};
      vecs[4]  = '{"tie lsb0",       7'd0,    8'h90, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40};
      vecs[5]  = '{"tie sticky",     7'd0,    8'h90, 1'b0, 1'b1, 1'b0, 1'b0, 8'h41};
      vecs[6]  = '{"sat le55",       7'd55,   8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F};
      vecs[7]  = '{"sat le63",       7'd63,   8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 8'h7F};
      vecs[8]  = '{"sat le-64",      7'h40,   8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01};
      vecs[9]  = '{"nar",            7'd0,    8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80};
      vecs[10] = '{"zero",           7'd9,    8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
      vecs[11] = '{"nar over zero",  7'd0,    8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 8'h80};
      vecs[12] = '{"sat le-55",      7'h49,   8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01};
      vecs[13] = '{"k-6 rounds up",  7'h57,   8'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02};
      vecs[14] = '{"k5 rounds max",  7'd47,   8'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F};
      vecs[15] = '{"k5 neg",         7'd40,   8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 8'h82};

      bus.in_valid  = 1'b0;
      bus.in_le     = '0;
      bus.in_mant   = '0;
      bus.in_sign   = 1'b0;
      bus.in_sticky = 1'b0;
      bus.in_zero   = 1'b0;
      bus.in_nar    = 1'b0;
      bus.out_ready = 1'b0;

      #12;
      checkOutput("reset out_valid", bus.out_valid, 0);
      checkOutput("reset out_posit", bus.out_posit, 0);
      rst_n = 1'b1;
      #1;
      checkOutput("reset release in_ready", bus.in_ready, 1);
      bus.out_ready = 1'b1;
      scoreOn = 1'b1;

      foreach (vecs[i]) applyStimulus(vecs[i]);

      $display("[TB] randomized traffic");
      repeat (400) begin
         @(posedge clk); #1;
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.in_le     = 7'($urandom);
         bus.in_mant   = {1'b1, 7'($urandom)};
         bus.in_sign   = 1'($urandom_range(0, 1));
         bus.in_sticky = 1'($urandom_range(0, 1));
         bus.in_zero   = ($urandom_range(0, 15) == 0);
         bus.in_nar    = ($urandom_range(0, 15) == 0);
         bus.out_ready = ($urandom_range(0, 9) < 6);
      end
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      waitCnt = 0;
      while (expQ.size() != 0 && waitCnt < 20) begin
         @(posedge clk); #1;
         waitCnt++;
      end
      checkOutput("random drain empty", expQ.size(), 0);

      $display("[TB] backpressure sequence");
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         driveBeat(7'(i * 13 - 20), 8'(8'h80 | (i * 23)), 1'(i % 2));
         if (bus.in_ready) begin
            accepted++;
            bpExp.push_back(posModel(bus.in_sign, 1'b0, 1'b0, bus.in_le, bus.in_mant, 1'b0));
         end
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      checkOutput("bp accepted count", accepted, 3);
      checkOutput("bp in_ready low", bus.in_ready, 0);
      checkOutput("bp out_valid", bus.out_valid, 1);
      held = bus.out_posit;
      repeat (3) begin
         @(posedge clk); #1;
      end
      checkOutput("bp out_posit stable", bus.out_posit, held);
      bus.out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 10; c++) begin
         if (bus.out_valid) begin
            if (got < bpExp.size()) checkOutput($sformatf("bp beat %0d", got), bus.out_posit, bpExp[got]);
            got++;
         end
         @(posedge clk); #1;
      end
      checkOutput("bp beat count", got, 3);

      $display("[TB] async reset sequence");
      bus.out_ready = 1'b0;
      driveBeat(7'h7A, 8'hC0, 1'b0);
      @(posedge clk); #1;
      driveBeat(7'd0, 8'hB0, 1'b1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      checkOutput("rst pre out_valid", bus.out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst async out_valid", bus.out_valid, 0);
      checkOutput("rst async out_posit", bus.out_posit, 0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      #1;
      checkOutput("rst release in_ready", bus.in_ready, 1);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      driveBeat(7'd0, 8'h80, 1'b0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      got = 0;
      for (int c = 0; c < 8; c++) begin
         if (bus.out_valid) begin
            checkOutput("rst new beat", bus.out_posit, 8'h40);
            got++;
         end
         @(posedge clk); #1;
      end
      checkOutput("rst beat count", got, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule

// File: doc/posit_encoder.md
Name: posit_encoder

Overview:
- Pipelined output stage sitting directly downstream of Posit_Adder.
- Consumes the adder's decoded result: sign, combined regime-exponent (LE), normalised mantissa with sticky bit, and zero/NaR flags.
- Packs the result into an N-bit posit with round-to-nearest-even and saturation.
- Uses a valid/ready handshake with a 3-stage pipeline so it can drive register files or downstream units under backpressure.

Parameters:
N, 8, posit width in bits.
ES, 3, exponent field width.
RS, log2(N), regime-count width; LE width is ES+RS+1.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  input beat valid.
in_ready  output  1  stage can accept a beat this cycle.
in_sign  input  1  result sign (1 = negative).
in_zero  input  1  result is exactly zero.
in_nar  input  1  result is NaR.
in_le  input  ES+RS+1  signed combined scale, k*2^ES + e.
in_mant  input  N  normalised mantissa; MSB is the hidden 1, N-1 fraction bits below it.
in_sticky  input  1  OR of all mantissa bits discarded upstream.
out_valid  output  1  output posit valid.
out_ready  input  1  consumer accepts the output this cycle.
out_posit  output  N  encoded posit.

Behaviour:
- Reset (asynchronous, rst_n low): all stage valid bits = 0, out_valid = 0, out_posit = 0.
  - Reset mid-operation discards every in-flight beat.
  - in_ready = 1 in the first cycle after release.
- Pipeline control:
  - Global advance enable adv = out_ready | ~out_valid; in_ready = adv.
  - A beat is transferred when in_valid & in_ready.
  - When adv = 0, all stages hold their data and valid bits, and out_posit is stable.
  - Latency is 3 cycles when there is no stall; throughput is 1 beat/cycle.
  - Bubbles are not collapsed: each stage is independent of the others, but all share adv.
- Stage 1: register the inputs; compute k = in_le >>> ES (arithmetic shift, i.e. floor) and e = in_le[ES-1:0].
- Stage 2: build the unrounded body, MSB first.
  - Regime:
    - k >= 0: (k+1) ones then a zero.
    - k < 0: (-k) zeros then a one.
  - Then e (ES bits), then the fraction in_mant[N-2:0].
  - Keep the top N-1 bits as the body; from the rest derive guard = first dropped bit and sticky = OR(remaining dropped bits, in_sticky).
- Saturation, decided in stage 2 and overriding rounding:
  - k >= N-2 → body = maxpos magnitude (all ones, 0x7F for N=8).
  - k <= -(N-1) → body = minpos magnitude (0x01).
  - A nonzero value never encodes to 0 or to NaR.
- Stage 3:
  - Rounding: round up iff guard & (sticky | body LSB). The increment may carry into the exponent or regime; this is legal posit behaviour.
  - Clamp: if the rounded magnitude would exceed maxpos, use maxpos.
  - Result: out_posit = {0, body}; if in_sign, out_posit = two's complement of that value.
- Special cases (checked in order, after the stage-3 result):
  - in_nar → 1 followed by N-1 zeros (0x80).
  - else in_zero → 0.
  - in_nar wins if both flags are set.
  - Sign and mantissa are ignored for both special cases.
- Arithmetic: all intermediate shift widths are at least 2N bits, so no regime/exponent/fraction bits are lost before the guard/sticky extraction.

Test Plan:
1. in_le=0, in_mant=8'b1000_0000, sign=0, sticky=0 → out_posit=0x40, out_valid 3 cycles after acceptance.
2. in_le=-6 (k=-1, e=2), in_mant=8'b1100_0000:
   - sign=0 → 0x2A.
   - sign=1 → 0xD6.
3. Rounding, in_le=0:
   - in_mant=8'b1011_0000 (tie, LSB=1) → 0x42.
   - in_mant=8'b1001_0000 (tie, LSB=0) → 0x40.
   - in_mant=8'b1001_0000 with sticky=1 → 0x41.
4. Saturation and special cases:
   - in_le=55 → 0x7F; in_le=63 → 0x7F; in_le=-64 → 0x01.
   - in_nar=1 → 0x80.
   - in_zero=1 → 0x00.
5. Backpressure: stream 5 beats back-to-back with out_ready=0 → exactly 3 accepted, then in_ready=0 and out_posit held stable. Raise out_ready → all beats emerge in order with no loss or duplication.
6. Assert rst_n=0 asynchronously with 2 beats in flight → out_valid drops immediately, with no clock edge needed. After release, a new beat (in_le=0, in_mant=0x80) yields 0x40 only.
